// File: rtl/sensor_debounce.sv
// sensor_debounce: conditions four asynchronous sensor / limit-switch inputs
// for the tarp motor controller. Each input is synchronized and debounced;
// the light and rain channels also get a minimum dwell after each change.
// The outputs are held at safe values until the synchronizers and debounce
// windows have filled after reset.

// One debounced channel: 2-flop synchronizer, debounce counter and an
// optional dwell counter.
module sensor_debounce_ch #(
  parameter int DEB_CYCLES  = 8,
  parameter int HOLD_CYCLES = 16,
  parameter bit HAS_HOLD    = 1'b0,
  parameter bit RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  input  logic valid,
  input  logic load,
  output logic out
);
  localparam logic [7:0] DEB_LAST  = 8'(DEB_CYCLES - 1);
  // Channels without a dwell load zero, so the dwell never becomes active.
  localparam logic [7:0] HOLD_LOAD = HAS_HOLD ? 8'(HOLD_CYCLES) : 8'd0;

  logic       sync_q1;
  logic       sync_q2;
  logic [7:0] deb_cnt;
  logic [7:0] hold_cnt;
  logic       hold_busy;
  logic       differs;
  logic       fire;

  assign hold_busy = (hold_cnt != 8'd0);
  assign differs   = (sync_q2 != out);
  // The output takes the new level once it has differed for DEB_CYCLES
  // consecutive cycles with no dwell pending.
  assign fire      = valid && !hold_busy && differs && (deb_cnt == DEB_LAST);

  // Two-flop synchronizer; only the second stage is used downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
    end
  end

  // Debounce counter: counts consecutive mismatching cycles, restarts on any
  // match, on a change, during the dwell and before the outputs are valid.
  always_ff @(posedge clk) begin
    if (rst || load || !valid || hold_busy || !differs || fire) begin
      deb_cnt <= 8'd0;
    end else begin
      deb_cnt <= deb_cnt + 8'd1;
    end
  end

  // Dwell counter: armed on each output change, counts down to zero.
  always_ff @(posedge clk) begin
    if (rst || load || !valid) begin
      hold_cnt <= 8'd0;
    end else if (fire) begin
      hold_cnt <= HOLD_LOAD;
    end else if (hold_busy) begin
      hold_cnt <= hold_cnt - 8'd1;
    end
  end

  // Output register: safe value in reset, snapshot of sync when the outputs
  // become valid, then debounced changes only.
  always_ff @(posedge clk) begin
    if (rst) begin
      out <= RST_VAL;
    end else if (load || fire) begin
      out <= sync_q2;
    end
  end
endmodule

module sensor_debounce #(
  parameter int DEB_CYCLES  = 8,
  parameter int HOLD_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_L,
  input  logic raw_U,
  input  logic raw_Fe,
  input  logic raw_Fd,
  output logic L_o,
  output logic U_o,
  output logic Fe_o,
  output logic Fd_o,
  output logic valid,
  output logic fault
);
  localparam int NUM_CH = 4;
  // Channel order {L, U, Fe, Fd}. Reset values make the motor controller
  // stop: both limits asserted, no light, no rain.
  localparam logic [NUM_CH-1:0] RST_VEC  = 4'b0011;
  localparam logic [NUM_CH-1:0] HOLD_VEC = 4'b1100;
  // valid rises on the (DEB_CYCLES+2)th edge with reset low; the counter is
  // one bit wider than the debounce counters so DEB_CYCLES = 255 still fits.
  localparam logic [8:0] VLD_LAST = 9'(DEB_CYCLES + 1);

  typedef enum logic {ST_WAIT, ST_RUN} state_t;

  state_t            state;
  state_t            state_nx;
  logic [8:0]        vld_cnt;
  logic [8:0]        vld_cnt_nx;
  logic              load;
  logic              valid_int;
  logic [NUM_CH-1:0] raw_vec;
  logic [NUM_CH-1:0] out_vec;

  assign raw_vec   = {raw_L, raw_U, raw_Fe, raw_Fd};
  assign valid_int = (state == ST_RUN);

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      sensor_debounce_ch #(
        .DEB_CYCLES (DEB_CYCLES),
        .HOLD_CYCLES(HOLD_CYCLES),
        .HAS_HOLD   (HOLD_VEC[i]),
        .RST_VAL    (RST_VEC[i])
      ) u_ch (
        .clk  (clk),
        .rst  (rst),
        .raw  (raw_vec[i]),
        .valid(valid_int),
        .load (load),
        .out  (out_vec[i])
      );
    end
  endgenerate

  assign {L_o, U_o, Fe_o, Fd_o} = out_vec;
  assign valid = valid_int;

  // Power-up sequencer state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_WAIT;
      vld_cnt <= 9'd0;
    end else begin
      state   <= state_nx;
      vld_cnt <= vld_cnt_nx;
    end
  end

  // Power-up sequencer: wait until the synchronizers and one debounce window
  // have filled, then load every channel with its sync value once.
  always_comb begin
    state_nx   = state;
    vld_cnt_nx = vld_cnt;
    load       = 1'b0;
    case (state)
      ST_WAIT: begin
        if (vld_cnt == VLD_LAST) begin
          load       = 1'b1;
          state_nx   = ST_RUN;
          vld_cnt_nx = 9'd0;
        end else begin
          vld_cnt_nx = vld_cnt + 9'd1;
        end
      end
      ST_RUN: begin
        state_nx = ST_RUN;
      end
      default: begin
        state_nx   = ST_WAIT;
        vld_cnt_nx = 9'd0;
      end
    endcase
  end

  // Fault flag: both limit switches reported at once while outputs are valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      fault <= 1'b0;
    end else begin
      fault <= valid_int && Fe_o && Fd_o;
    end
  end
endmodule

// File: tb/tb_sensor_debounce.sv
// Bench for sensor_debounce: two instances (default and minimum-window,
// no-dwell parameters) share one stimulus. A window-based reference model
// predicts every cycle's outputs into per-instance queues; a negedge monitor
// pops and compares. Directed latency checks cover the named scenarios.
module tb_sensor_debounce;
  localparam int DEB0  = 8;
  localparam int HOLD0 = 16;
  localparam int DEB1  = 2;
  localparam int HOLD1 = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic raw_L = 1'b0, raw_U = 1'b0, raw_Fe = 1'b0, raw_Fd = 1'b1;
  logic L0, U0, Fe0, Fd0, v0, f0;
  logic L1, U1, Fe1, Fd1, v1, f1;

  always #5 clk = ~clk;

  sensor_debounce #(.DEB_CYCLES(DEB0), .HOLD_CYCLES(HOLD0)) dut0 (
    .clk(clk), .rst(rst), .raw_L(raw_L), .raw_U(raw_U), .raw_Fe(raw_Fe),
    .raw_Fd(raw_Fd), .L_o(L0), .U_o(U0), .Fe_o(Fe0), .Fd_o(Fd0),
    .valid(v0), .fault(f0));

  sensor_debounce #(.DEB_CYCLES(DEB1), .HOLD_CYCLES(HOLD1)) dut1 (
    .clk(clk), .rst(rst), .raw_L(raw_L), .raw_U(raw_U), .raw_Fe(raw_Fe),
    .raw_Fd(raw_Fd), .L_o(L1), .U_o(U1), .Fe_o(Fe1), .Fd_o(Fd1),
    .valid(v1), .fault(f1));

  int    checks = 0;
  int    failures = 0;
  string phase = "reset";

  // Reference model state, per instance k and channel c (0=L,1=U,2=Fe,3=Fd).
  bit   m_s1[2][4];
  bit   m_s2[2][4];
  bit   m_out[2][4];
  bit   m_vld[2];
  bit   m_flt[2];
  int   m_low[2];
  int   m_free[2][4];      // first edge that may count toward a change
  bit   m_hist[2][4][512]; // sync value seen by edge n, ring-indexed
  int   n_edge = 0;
  logic [5:0] q0[$];
  logic [5:0] q1[$];
  logic [5:0] e0, e1;

  // An output flips at edge n when the sync value differed from it on every
  // one of the last DEB edges, all of them at or after the channel's free edge.
  task automatic model_step(input int k, input int deb, input int hold,
                            input logic r, input logic [3:0] rv,
                            output logic [5:0] e);
    bit f_next;
    bit flip;
    int lo;
    if (r) begin
      for (int c = 0; c < 4; c++) begin
        m_s1[k][c] = 1'b0; m_s2[k][c] = 1'b0;
        m_out[k][c] = (c >= 2); m_free[k][c] = 0;
      end
      m_vld[k] = 1'b0; m_flt[k] = 1'b0; m_low[k] = 0;
    end else begin
      f_next = m_vld[k] && m_out[k][2] && m_out[k][3];
      for (int c = 0; c < 4; c++) m_hist[k][c][n_edge % 512] = m_s2[k][c];
      if (!m_vld[k]) begin
        m_low[k]++;
        if (m_low[k] == deb + 2) begin
          m_vld[k] = 1'b1;
          for (int c = 0; c < 4; c++) begin
            m_out[k][c] = m_s2[k][c];
            m_free[k][c] = n_edge + 1;
          end
        end
      end else begin
        for (int c = 0; c < 4; c++) begin
          lo = n_edge - deb + 1;
          if (lo >= m_free[k][c]) begin
            flip = 1'b1;
            for (int s = lo; s <= n_edge; s++)
              if (m_hist[k][c][s % 512] == m_out[k][c]) flip = 1'b0;
            if (flip) begin
              m_out[k][c] = !m_out[k][c];
              m_free[k][c] = n_edge + 1 + ((c < 2) ? hold : 0);
            end
          end
        end
      end
      m_flt[k] = f_next;
      for (int c = 0; c < 4; c++) begin
        m_s2[k][c] = m_s1[k][c];
        m_s1[k][c] = rv[3-c];
      end
    end
    e = {m_vld[k], m_flt[k], m_out[k][0], m_out[k][1], m_out[k][2], m_out[k][3]};
  endtask

  // Reference model: one step per rising edge; inputs only move at edge+1.
  always @(posedge clk) begin
    n_edge++;
    model_step(0, DEB0, HOLD0, rst, {raw_L, raw_U, raw_Fe, raw_Fd}, e0);
    q0.push_back(e0);
    model_step(1, DEB1, HOLD1, rst, {raw_L, raw_U, raw_Fe, raw_Fd}, e1);
    q1.push_back(e1);
  end

  task automatic sb_check(input string name, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s (%s) t=%0t got={v,f,L,U,Fe,Fd}=%b exp=%b", name, phase, $time, act, exp);
    end
  endtask

  // Monitor: compare every cycle's outputs against the queued prediction.
  always @(negedge clk) begin
    if (q0.size() > 0) sb_check("sb_dut0", {v0, f0, L0, U0, Fe0, Fd0}, q0.pop_front());
    if (q1.size() > 0) sb_check("sb_dut1", {v1, f1, L1, U1, Fe1, Fd1}, q1.pop_front());
  end

  task automatic expect_int(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0: return v0;
      1: return U0;
      2: return L0;
      3: return f0;
      default: return Fd0;
    endcase
  endfunction

  // Count rising edges until a dut0 signal reaches lvl; bounded by limit.
  task automatic edges_until(input int sel, input logic lvl, input int limit, output int k);
    k = 0;
    do begin
      @(posedge clk); #1; k++;
    end while (sig(sel) !== lvl && k < limit);
  endtask

  int k;
  int seen;
  int p;
  int pick[4] = '{2, 5, 12, 40};

  initial begin
    // Reset release with {L,U,Fe,Fd} = 0001.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    phase = "power_up";
    edges_until(0, 1'b1, 50, k);
    expect_int("valid_latency", k, DEB0 + 2);
    expect_int("valid_outputs", {L0, U0, Fe0, Fd0, f0}, 5'b00010);

    // Rain: held change, then a short pulse that must be rejected.
    phase = "rain";
    repeat (3) @(posedge clk);
    #1 raw_U = 1'b1;
    edges_until(1, 1'b1, 50, k);
    expect_int("u_rise_latency", k, DEB0 + 2);
    raw_U = 1'b0;
    edges_until(1, 1'b0, 80, k);
    expect_int("u_hold_fall", k, HOLD0 + DEB0);
    repeat (HOLD0 + 2) @(posedge clk);
    #1 raw_U = 1'b1;
    repeat (5) @(posedge clk);
    #1 raw_U = 1'b0;
    seen = 0;
    repeat (25) begin @(posedge clk); #1; if (U0 !== 1'b0) seen++; end
    expect_int("u_glitch_rejected", seen, 0);

    // Light: return to 0 two cycles after L_o rises; dwell delays the fall.
    phase = "light_hold";
    raw_L = 1'b1;
    edges_until(2, 1'b1, 50, k);
    expect_int("l_rise_latency", k, DEB0 + 2);
    repeat (2) @(posedge clk);
    #1 raw_L = 1'b0;
    k = 2;
    do begin @(posedge clk); #1; k++; end while (L0 !== 1'b0 && k < 100);
    expect_int("l_hold_fall", k, HOLD0 + DEB0);

    // Reset mid-debounce (U counter at 5) and mid-dwell (L hold nonzero).
    phase = "mid_reset";
    raw_U = 1'b1;
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    expect_int("reset_outputs", {v0, f0, L0, U0, Fe0, Fd0}, 6'b000011);
    k = 0; seen = 0;
    do begin
      @(posedge clk); #1; k++;
      if (!v0 && U0 !== 1'b0) seen++;
    end while (v0 !== 1'b1 && k < 50);
    expect_int("revalid_latency", k, DEB0 + 2);
    expect_int("u_no_toggle_invalid", seen, 0);
    expect_int("u_loaded_at_valid", U0, 1);

    // Limit switches: both active raises fault one edge later.
    phase = "fault";
    repeat (2) @(posedge clk);
    #1 raw_Fe = 1'b1;
    edges_until(3, 1'b1, 50, k);
    expect_int("fault_rise", k, DEB0 + 3);
    raw_Fd = 1'b0;
    edges_until(3, 1'b0, 50, k);
    expect_int("fault_fall", k, DEB0 + 3);
    expect_int("fd_fell", Fd0, 0);

    // Random traffic with varying toggle rates and occasional reset pulses.
    phase = "random";
    for (int seg = 0; seg < 30; seg++) begin
      p = pick[$urandom_range(0, 3)];
      for (int c = 0; c < 100; c++) begin
        @(posedge clk); #1;
        if ($urandom_range(0, p - 1) == 0) raw_L  = ~raw_L;
        if ($urandom_range(0, p - 1) == 0) raw_U  = ~raw_U;
        if ($urandom_range(0, p - 1) == 0) raw_Fe = ~raw_Fe;
        if ($urandom_range(0, p - 1) == 0) raw_Fd = ~raw_Fd;
        if (rst) rst = 1'b0;
        else if ($urandom_range(0, 399) == 0) rst = 1'b1;
      end
    end

    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    expect_int("sb_drained", q0.size() + q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sensor_debounce.md
SENSOR_DEBOUNCE -- requirements
Module: sensor_debounce

Interface
REQ-001 Parameter DEB_CYCLES, default 8, consecutive stable cycles required before any filtered output changes; legal range 2..255.
REQ-002 Parameter HOLD_CYCLES, default 16, minimum dwell in cycles after an L_o or U_o change; legal range 0..255; 0 disables the dwell.
REQ-003 Port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port raw_L  input  1  asynchronous light sensor, 1 = high sun incidence.
REQ-006 Port raw_U  input  1  asynchronous rain sensor, 1 = high rain incidence.
REQ-007 Port raw_Fe  input  1  asynchronous left limit switch, 1 = tarp at left edge (area covered).
REQ-008 Port raw_Fd  input  1  asynchronous right limit switch, 1 = tarp at right edge (area open).
REQ-009 Port L_o  output  1  filtered light; feeds the motor controller input L.
REQ-010 Port U_o  output  1  filtered rain; feeds the motor controller input U.
REQ-011 Port Fe_o  output  1  filtered left limit; feeds the motor controller input Fe.
REQ-012 Port Fd_o  output  1  filtered right limit; feeds the motor controller input Fd.
REQ-013 Port valid  output  1  1 = filtered outputs reflect the sensors.
REQ-014 Port fault  output  1  1 = both limit switches active (Fe_o = Fd_o = 1) while valid.

Function
REQ-015 Each raw input SHALL pass through its own 2-flop synchronizer; only the second-stage value (sync) is used downstream.
REQ-016 Each channel SHALL have an 8-bit debounce counter that clears on any cycle where sync equals the channel output.
REQ-017 The counter SHALL increment on each cycle where sync differs from the output; when it holds DEB_CYCLES-1 and sync still differs, the output SHALL take sync at that edge and the counter SHALL clear.
REQ-018 An isolated raw level change held stable SHALL appear on the output exactly DEB_CYCLES+2 rising edges after the edge that first samples it.
REQ-019 A raw pulse or glitch shorter than DEB_CYCLES cycles after synchronization SHALL produce no output change.
REQ-020 L and U SHALL each have an 8-bit hold counter, loaded with HOLD_CYCLES on the edge its output toggles and decremented each cycle while nonzero.
REQ-021 While a channel's hold counter is nonzero, its debounce counter SHALL be held at 0 and its output SHALL not change; debouncing SHALL restart when the hold counter reaches 0.
REQ-022 Fe_o and Fd_o SHALL have no hold; limit-switch changes SHALL propagate as soon as debounced.
REQ-023 valid SHALL rise at the (DEB_CYCLES+2)th rising edge after the edge where rst is sampled low, and SHALL stay 1 until the next reset.
REQ-024 On the edge where valid rises, all four outputs SHALL load their current sync values directly; counters SHALL clear and no hold SHALL start.
REQ-025 While valid = 0, outputs SHALL hold their reset values, forcing the downstream motor controller to stop (A = 0, B = 0).
REQ-026 fault SHALL be registered: it SHALL be 1 on the cycle after Fe_o = Fd_o = 1 with valid = 1, and 0 otherwise.
REQ-027 All channels SHALL be independent; simultaneous changes on several inputs SHALL each follow REQ-017 with no mutual interaction.

Reset
REQ-028 With rst = 1 at a rising edge: L_o = 0, U_o = 0, Fe_o = 1, Fd_o = 1, valid = 0, fault = 0; all synchronizers, debounce, hold and valid counters = 0.
REQ-029 Asserting rst mid-debounce or mid-hold SHALL abort it with no output change except the reset values, and SHALL restart the valid sequence of REQ-023.

Verification
REQ-030 Reset release with raw = {L,U,Fe,Fd} = 0001 and defaults -> valid = 0 and outputs 0,0,1,1 for 9 edges; at edge 10 valid = 1, outputs 0,0,0,1, fault = 0.
REQ-031 After valid, raw_U 0->1 held -> U_o = 1 exactly 10 edges after first sampling; raw_U high pulse of 5 cycles -> U_o stays 0.
REQ-032 raw_L toggles 0->1, then returns to 0 two cycles after L_o rises -> L_o stays 1 for 16 cycles of hold, then falls 8 cycles later (24 edges after the rise).
REQ-033 raw_Fe = raw_Fd = 1 held after valid -> both outputs 1 after 10 edges, fault = 1 on the next edge; releasing raw_Fd -> fault = 0 one edge after Fd_o falls.
REQ-034 rst pulsed for one cycle while the U counter is at 5 and the L hold counter is nonzero -> reset values on the next edge, valid = 0 for 9 edges, no spurious U_o toggle.
